shot_arbiter: RTL and testbench

Shared-access controller for the two game boards (player board, PC board) held in one synchronous-read RAM. It arbitrates ship-placement, player-shot and PC-shot requests from the game FSM and PC move generator, and performs each as a read-evaluate-write sequence. It returns hit/miss/repeat results, tracks remaining ship cells per board, and raises the victory flags the game FSM tests in its check-victory states. After reset and on every new game, it sweeps both boards clear.

---
 rtl/shot_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_shot_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_arbiter.sv
// Shared-board access controller: arbitrates placement and shot requests into a
// read-evaluate-write sequence on a sync-read RAM, tracks ship counts and victory flags.
module shot_arbiter #(
  parameter int unsigned CELLS = 25,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             s_req,
  input  logic             s_board,
  input  logic [IDX_W-1:0] s_idx,
  input  logic             p_req,
  input  logic [IDX_W-1:0] p_idx,
  input  logic             c_req,
  input  logic [IDX_W-1:0] c_idx,
  output logic [IDX_W:0]   mem_addr,
  output logic             mem_we,
  output logic [1:0]       mem_wdata,
  input  logic [1:0]       mem_rdata,
  output logic             s_done,
  output logic             p_done,
  output logic             c_done,
  output logic             clr_done,
  output logic [1:0]       res,
  output logic             busy,
  output logic [4:0]       left_pl,
  output logic [4:0]       left_pc,
  output logic             win_p,
  output logic             win_c
);

  localparam logic [1:0] CellEmpty = 2'b00;
  localparam logic [1:0] CellShip  = 2'b01;
  localparam logic [1:0] CellMiss  = 2'b10;
  localparam logic [1:0] CellHit   = 2'b11;

  localparam logic [1:0] ResOk     = 2'b00;
  localparam logic [1:0] ResMiss   = 2'b01;
  localparam logic [1:0] ResHit    = 2'b10;
  localparam logic [1:0] ResRepeat = 2'b11;

  localparam logic [IDX_W-1:0] LastCell = IDX_W'(CELLS - 1);

  typedef enum logic [2:0] {StIdle, StRead, StEval, StResp, StClr} state_e;
  typedef enum logic [1:0] {WhoS, WhoP, WhoC} who_e;

  state_e           state_q, state_d;
  who_e             who_q, who_d;
  logic             board_q, board_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       res_q, res_d;
  logic             swb_q, swb_d;
  logic [IDX_W-1:0] swc_q, swc_d;
  logic             pend_q, pend_d;
  logic             clr_done_q, clr_done_d;
  logic [4:0]       left_pl_q, left_pl_d, left_pc_q, left_pc_d;
  logic             armed_pl_q, armed_pl_d, armed_pc_q, armed_pc_d;
  logic             we_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StClr;
      who_q      <= WhoS;
      board_q    <= 1'b0;
      idx_q      <= '0;
      res_q      <= ResOk;
      swb_q      <= 1'b0;
      swc_q      <= '0;
      pend_q     <= 1'b0;
      clr_done_q <= 1'b0;
      left_pl_q  <= '0;
      left_pc_q  <= '0;
      armed_pl_q <= 1'b0;
      armed_pc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      who_q      <= who_d;
      board_q    <= board_d;
      idx_q      <= idx_d;
      res_q      <= res_d;
      swb_q      <= swb_d;
      swc_q      <= swc_d;
      pend_q     <= pend_d;
      clr_done_q <= clr_done_d;
      left_pl_q  <= left_pl_d;
      left_pc_q  <= left_pc_d;
      armed_pl_q <= armed_pl_d;
      armed_pc_q <= armed_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    who_d      = who_q;
    board_d    = board_q;
    idx_d      = idx_q;
    res_d      = res_q;
    swb_d      = swb_q;
    swc_d      = swc_q;
    pend_d     = pend_q | clr;
    clr_done_d = 1'b0;
    left_pl_d  = left_pl_q;
    left_pc_d  = left_pc_q;
    armed_pl_d = armed_pl_q;
    armed_pc_d = armed_pc_q;
    we_c       = 1'b0;
    mem_wdata  = CellEmpty;
    mem_addr   = {board_q, idx_q};

    case (state_q)
      StIdle: begin
        if (pend_q || clr) begin
          state_d = StClr;
          swb_d   = 1'b0;
          swc_d   = '0;
          pend_d  = 1'b0;
        end else if (s_req) begin
          state_d = StRead;
          who_d   = WhoS;
          board_d = s_board;
          idx_d   = s_idx;
        end else if (p_req) begin
          state_d = StRead;
          who_d   = WhoP;
          board_d = 1'b1;
          idx_d   = p_idx;
        end else if (c_req) begin
          state_d = StRead;
          who_d   = WhoC;
          board_d = 1'b0;
          idx_d   = c_idx;
        end
      end
      StRead: state_d = StEval;
      StEval: begin
        state_d = StResp;
        if (who_q == WhoS) begin
          if (mem_rdata == CellEmpty) begin
            we_c      = 1'b1;
            mem_wdata = CellShip;
            res_d     = ResOk;
            if (board_q) begin
              left_pc_d  = left_pc_q + 5'd1;
              armed_pc_d = 1'b1;
            end else begin
              left_pl_d  = left_pl_q + 5'd1;
              armed_pl_d = 1'b1;
            end
          end else begin
            res_d = ResRepeat;
          end
        end else begin
          case (mem_rdata)
            CellShip: begin
              we_c      = 1'b1;
              mem_wdata = CellHit;
              res_d     = ResHit;
              if (board_q) left_pc_d = left_pc_q - 5'd1;
              else         left_pl_d = left_pl_q - 5'd1;
            end
            CellEmpty: begin
              we_c      = 1'b1;
              mem_wdata = CellMiss;
              res_d     = ResMiss;
            end
            default: res_d = ResRepeat;
          endcase
        end
      end
      StResp: state_d = StIdle;
      StClr: begin
        we_c       = 1'b1;
        mem_addr   = {swb_q, swc_q};
        pend_d     = 1'b0;
        left_pl_d  = '0;
        left_pc_d  = '0;
        armed_pl_d = 1'b0;
        armed_pc_d = 1'b0;
        if (clr) begin
          swb_d = 1'b0;
          swc_d = '0;
        end else if (swc_q == LastCell) begin
          if (swb_q) begin
            state_d    = StIdle;
            clr_done_d = 1'b1;
          end else begin
            swb_d = 1'b1;
            swc_d = '0;
          end
        end else begin
          swc_d = swc_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Gate with reset so a pending write is dropped the instant reset asserts.
  assign mem_we   = we_c & rst;
  assign busy     = (state_q != StIdle);
  assign s_done   = (state_q == StResp) && (who_q == WhoS);
  assign p_done   = (state_q == StResp) && (who_q == WhoP);
  assign c_done   = (state_q == StResp) && (who_q == WhoC);
  assign clr_done = clr_done_q;
  assign res      = res_q;
  assign left_pl  = left_pl_q;
  assign left_pc  = left_pc_q;
  assign win_p    = armed_pc_q && (left_pc_q == 5'd0);
  assign win_c    = armed_pl_q && (left_pl_q == 5'd0);

endmodule

// File: tb/tb_shot_arbiter.sv
// Self-checking bench for shot_arbiter: table vectors, corner-case sequences and
// randomized operations against a board-level game model.
module tb_shot_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       s_req = 1'b0, s_board = 1'b0, p_req = 1'b0, c_req = 1'b0;
  logic [4:0] s_idx = '0, p_idx = '0, c_idx = '0;
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata, mem_rdata;
  logic       s_done, p_done, c_done, clr_done, busy, win_p, win_c;
  logic [1:0] res;
  logic [4:0] left_pl, left_pc;

  shot_arbiter #(.CELLS(25), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .s_req(s_req), .s_board(s_board), .s_idx(s_idx),
    .p_req(p_req), .p_idx(p_idx), .c_req(c_req), .c_idx(c_idx),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .s_done(s_done), .p_done(p_done), .c_done(c_done), .clr_done(clr_done),
    .res(res), .busy(busy), .left_pl(left_pl), .left_pc(left_pc),
    .win_p(win_p), .win_c(win_c)
  );

  always #5 clk = ~clk;

  // Synchronous-read board RAM.
  logic [1:0] ram [64];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Activity monitors.
  int          we_cnt = 0, busy_cnt = 0, cd_cnt = 0, sdone_cnt = 0, ovl_cnt = 0;
  logic        mask_clr = 1'b1;
  logic [63:0] wmask = '0;
  always @(posedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (rst && busy) busy_cnt <= busy_cnt + 1;
    if (clr_done) cd_cnt <= cd_cnt + 1;
    if (s_done) sdone_cnt <= sdone_cnt + 1;
    if (int'(s_done) + int'(p_done) + int'(c_done) > 1) ovl_cnt <= ovl_cnt + 1;
    if (mask_clr) wmask <= '0;
    else if (mem_we) wmask[mem_addr] <= 1'b1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Game model: cell values per board (0 empty, 1 ship, 2 miss, 3 hit) and armed flags.
  int mb [2][25];
  int marm [2];

  function automatic void model_clear();
    for (int b = 0; b < 2; b++) begin
      marm[b] = 0;
      for (int i = 0; i < 25; i++) mb[b][i] = 0;
    end
  endfunction

  function automatic int ships(input int b);
    int n = 0;
    for (int i = 0; i < 25; i++) if (mb[b][i] == 1) n++;
    return n;
  endfunction

  function automatic int model_op(input int op, input int b, input int idx);
    int tgt, r;
    tgt = (op == 0) ? b : ((op == 1) ? 1 : 0);
    if (op == 0) begin
      if (mb[tgt][idx] == 0) begin
        mb[tgt][idx] = 1;
        marm[tgt] = 1;
        r = 0;
      end else r = 3;
    end else begin
      case (mb[tgt][idx])
        0: begin mb[tgt][idx] = 2; r = 1; end
        1: begin mb[tgt][idx] = 3; r = 2; end
        default: r = 3;
      endcase
    end
    return r;
  endfunction

  // Issue one request and wait for its done; captures outputs in the done cycle.
  task automatic run_op(input int op, input int b, input int idx, output int r, output int lpl,
                        output int lpc, output int wp, output int wc, output int lat);
    int got = 0;
    @(posedge clk) #1;
    case (op)
      0: begin s_req = 1'b1; s_board = b[0]; s_idx = idx[4:0]; end
      1: begin p_req = 1'b1; p_idx = idx[4:0]; end
      default: begin c_req = 1'b1; c_idx = idx[4:0]; end
    endcase
    lat = 0; r = -1; lpl = -1; lpc = -1; wp = -1; wc = -1;
    while (got == 0 && lat < 40) begin
      @(negedge clk);
      lat++;
      if ((op == 0 && s_done) || (op == 1 && p_done) || (op == 2 && c_done)) begin
        got = 1; r = res; lpl = left_pl; lpc = left_pc; wp = win_p; wc = win_c;
      end
    end
    check("op_done_seen", got, 1);
    @(posedge clk) #1;
    s_req = 1'b0; p_req = 1'b0; c_req = 1'b0;
  endtask

  task automatic wait_clr_done(input string name);
    int seen = 0;
    for (int i = 0; i < 120 && seen == 0; i++) begin
      @(negedge clk);
      if (clr_done) seen = 1;
    end
    check(name, seen, 1);
  endtask

  task automatic pulse_clr();
    @(posedge clk) #1 clr = 1'b1;
    @(posedge clk) #1 clr = 1'b0;
    wait_clr_done("clr_done_after_pulse");
    model_clear();
  endtask

  typedef struct {int op; int b; int idx; int r; int lpl; int lpc; int wp; int wc;} vec_t;
  vec_t tbl [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r, lpl, lpc, wp, wc, lat, base_we, base_busy, base_cd, base_sd, base_ovl;
    int ts, tp, tc, rs, rp, rc, cyc;

    // Reset state.
    #1 rst = 1'b0;
    #2;
    check("rst_busy", busy, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_dones", {s_done, p_done, c_done, clr_done}, 0);
    check("rst_res", res, 0);
    check("rst_left", {left_pl, left_pc}, 0);
    check("rst_win", {win_p, win_c}, 0);
    @(negedge clk);
    @(negedge clk);
    base_we = we_cnt; base_busy = busy_cnt; base_cd = cd_cnt;
    rst = 1'b1;
    mask_clr = 1'b0;
    wait_clr_done("init_clr_done");
    check("init_idle_with_clr_done", busy, 0);
    @(negedge clk);
    check("init_sweep_writes", we_cnt - base_we, 50);
    check("init_busy_cycles", busy_cnt - base_busy, 50);
    check("init_clr_done_pulses", cd_cnt - base_cd, 1);
    check("init_sweep_addrs", wmask, 64'h01FF_FFFF_01FF_FFFF);
    check("init_left", {left_pl, left_pc}, 0);
    check("init_win", {win_p, win_c}, 0);

    // Table-driven vectors (op 0 place, 1 player shot, 2 PC shot).
    tbl[0] = '{0, 1, 7,  0, 0, 1, 0, 0};
    tbl[1] = '{0, 1, 7,  3, 0, 1, 0, 0};
    tbl[2] = '{1, 0, 7,  2, 0, 0, 1, 0};
    tbl[3] = '{1, 0, 7,  3, 0, 0, 1, 0};
    tbl[4] = '{1, 0, 3,  1, 0, 0, 1, 0};
    tbl[5] = '{0, 0, 12, 0, 1, 0, 1, 0};
    tbl[6] = '{2, 0, 12, 2, 0, 0, 1, 1};
    tbl[7] = '{2, 0, 12, 3, 0, 0, 1, 1};
    tbl[8] = '{2, 0, 0,  1, 0, 0, 1, 1};
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].b, tbl[i].idx, r, lpl, lpc, wp, wc, lat);
      check($sformatf("tbl%0d_res", i), r, tbl[i].r);
      check($sformatf("tbl%0d_left_pl", i), lpl, tbl[i].lpl);
      check($sformatf("tbl%0d_left_pc", i), lpc, tbl[i].lpc);
      check($sformatf("tbl%0d_win_p", i), wp, tbl[i].wp);
      check($sformatf("tbl%0d_win_c", i), wc, tbl[i].wc);
      check($sformatf("tbl%0d_latency", i), lat, 4);
    end
    check("ram_pc7_hit", ram[39], 3);
    check("ram_pc3_miss", ram[35], 2);
    check("ram_pl12_hit", ram[12], 3);
    check("ram_pl0_miss", ram[0], 2);

    // Simultaneous requests: service order s, p, c, 4 cycles apart.
    pulse_clr();
    base_ovl = ovl_cnt;
    @(posedge clk) #1;
    s_req = 1'b1; s_board = 1'b0; s_idx = 5'd1;
    p_req = 1'b1; p_idx = 5'd5;
    c_req = 1'b1; c_idx = 5'd1;
    ts = -1; tp = -1; tc = -1; rs = -1; rp = -1; rc = -1; cyc = 0;
    while ((ts < 0 || tp < 0 || tc < 0) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (s_done) begin ts = cyc; rs = res; end
      if (p_done) begin tp = cyc; rp = res; end
      if (c_done) begin tc = cyc; rc = res; end
      @(posedge clk) #1;
      if (s_done_seen(ts, cyc)) s_req = 1'b0;
      if (s_done_seen(tp, cyc)) p_req = 1'b0;
      if (s_done_seen(tc, cyc)) c_req = 1'b0;
    end
    s_req = 1'b0; p_req = 1'b0; c_req = 1'b0;
    check("sim_s_first_latency", ts, 4);
    check("sim_p_after_s", tp - ts, 4);
    check("sim_c_after_p", tc - tp, 4);
    check("sim_s_res", rs, 0);
    check("sim_p_res", rp, 1);
    check("sim_c_res", rc, 2);
    @(negedge clk);
    check("sim_no_overlap", ovl_cnt - base_ovl, 0);

    // clr pulsed during EVAL of a PC shot.
    pulse_clr();
    run_op(0, 0, 2, r, lpl, lpc, wp, wc, lat);
    check("ce_place_pl", r, 0);
    run_op(0, 1, 4, r, lpl, lpc, wp, wc, lat);
    check("ce_place_pc", r, 0);
    @(posedge clk) #1 c_req = 1'b1; c_idx = 5'd2;
    @(posedge clk) #1;
    @(posedge clk) #1 clr = 1'b1;
    @(posedge clk) #1 clr = 1'b0;
    @(negedge clk);
    check("ce_c_done", c_done, 1);
    check("ce_c_res", res, 2);
    check("ce_left_pl", left_pl, 0);
    check("ce_win_c", win_c, 1);
    @(posedge clk) #1 c_req = 1'b0;
    wait_clr_done("ce_clr_done");
    check("ce_left_after", {left_pl, left_pc}, 0);
    check("ce_win_after", {win_p, win_c}, 0);
    check("ce_ram_cleared", {ram[2], ram[36]}, 0);
    model_clear();

    // Reset asserted during EVAL of a placement.
    @(posedge clk) #1 s_req = 1'b1; s_board = 1'b1; s_idx = 5'd9;
    @(posedge clk) #1;
    @(posedge clk) #1;
    check("re_eval_writes", mem_we, 1);
    #2 rst = 1'b0;
    #1;
    check("re_mem_we_drop", mem_we, 0);
    check("re_busy", busy, 1);
    check("re_no_done", s_done, 0);
    s_req = 1'b0;
    base_sd = sdone_cnt;
    @(negedge clk);
    @(negedge clk);
    base_we = we_cnt;
    rst = 1'b1;
    wait_clr_done("re_clr_done");
    @(negedge clk);
    check("re_sweep_writes", we_cnt - base_we, 50);
    check("re_no_done_pulse", sdone_cnt - base_sd, 0);
    check("re_cell_untouched", ram[41], 0);
    check("re_left_pc", left_pc, 0);

    // Randomized operations against the game model.
    for (int n = 0; n < 250; n++) begin
      int k, op, b, idx, er;
      k = $urandom_range(0, 99);
      if (k < 3) begin
        pulse_clr();
        check("rnd_clr_left", {left_pl, left_pc}, 0);
      end else begin
        op  = (k < 45) ? 0 : ((k < 75) ? 1 : 2);
        b   = $urandom_range(0, 1);
        idx = $urandom_range(0, 5);
        er  = model_op(op, b, idx);
        run_op(op, b, idx, r, lpl, lpc, wp, wc, lat);
        check($sformatf("rnd%0d_res", n), r, er);
        check($sformatf("rnd%0d_left_pl", n), lpl, ships(0));
        check($sformatf("rnd%0d_left_pc", n), lpc, ships(1));
        check($sformatf("rnd%0d_win_p", n), wp, int'(marm[1] != 0 && ships(1) == 0));
        check($sformatf("rnd%0d_win_c", n), wc, int'(marm[0] != 0 && ships(0) == 0));
        check($sformatf("rnd%0d_latency", n), lat, 4);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // True in the cycle where a requester saw its done: drop req right after that edge.
  function automatic bit s_done_seen(input int t, input int now);
    return (t == now);
  endfunction

endmodule
